// File: rtl/finalsum_ctrl.sv
// Sequencer for a three-operand registered adder: walks two RAM regions in lockstep,
// feeding each adder result back as the next sum_0, and reports the accumulated total.
module finalsum_ctrl #(
  parameter int AW     = 10,
  parameter int CNT_W  = 10,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] len,
  input  logic [AW-1:0]    base1_addr,
  input  logic [AW-1:0]    base2_addr,
  input  logic [31:0]      init_val,
  output logic [AW-1:0]    ram1_addr,
  output logic [AW-1:0]    ram2_addr,
  output logic             ram_rd_en,
  output logic [31:0]      sum_0,
  input  logic [31:0]      final_sum,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result
);

  localparam int WC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] pair_cnt;
  logic [CNT_W-1:0] pair_nxt;
  logic [WC_W-1:0]  wait_cnt;
  logic [31:0]      acc;
  logic             wait_last;
  logic             more;
  logic             accept;

  // start is a strobe sampled only in IDLE (abort wins); there is no back-pressure,
  // the RAM and adder are assumed always ready and data returns RD_LAT cycles after ram_rd_en.
  assign accept    = (state == IDLE) && start && !abort;
  assign wait_last = (wait_cnt == WC_W'(RD_LAT - 1));
  assign pair_nxt  = pair_cnt + CNT_W'(1);
  assign more      = (pair_nxt < len_q);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (len == '0) ? DONE : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_last) state_nxt = CAPT;
      CAPT:    state_nxt = more ? ISSUE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // DONE already leads to IDLE, so its pulse survives an abort
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      pair_cnt  <= '0;
      wait_cnt  <= '0;
      acc       <= '0;
      ram1_addr <= '0;
      ram2_addr <= '0;
      result    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        len_q     <= len;
        ram1_addr <= base1_addr;
        ram2_addr <= base2_addr;
        acc       <= init_val;
        pair_cnt  <= '0;
        wait_cnt  <= '0;
        if (len == '0) result <= init_val;
      end
      if (state == WAIT) wait_cnt <= wait_last ? '0 : wait_cnt + WC_W'(1);
      // An aborted pair leaves the accumulator and addresses frozen
      if (state == CAPT && !abort) begin
        acc       <= final_sum;
        ram1_addr <= ram1_addr + AW'(1);
        ram2_addr <= ram2_addr + AW'(1);
        pair_cnt  <= pair_nxt;
        if (!more) result <= final_sum;
      end
    end
  end

  assign ram_rd_en = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign sum_0     = acc;

endmodule

// File: tb/tb_finalsum_ctrl.sv
// Bench for finalsum_ctrl: RD_LAT=1 and RD_LAT=3 instances, each with a RAM pair and
// registered adder, checked every cycle against a job-level timing/sum model.
module tb_finalsum_ctrl;
  localparam int AW    = 10;
  localparam int CNT_W = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start_v[2];
  logic             abort_v[2];
  logic [CNT_W-1:0] len;
  logic [AW-1:0]    base1;
  logic [AW-1:0]    base2;
  logic [31:0]      init_val;

  logic [AW-1:0] a1_v[2];
  logic [AW-1:0] a2_v[2];
  logic          rd_v[2];
  logic          busy_v[2];
  logic          done_v[2];
  logic [31:0]   s0_v[2];
  logic [31:0]   res_v[2];

  logic [31:0] mem1[2][DEPTH];
  logic [31:0] mem2[2][DEPTH];

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] rda1[$];
  logic [AW-1:0] rda2[$];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] fsum;
    logic [31:0] p1[LAT];
    logic [31:0] p2[LAT];

    finalsum_ctrl #(.AW(AW), .CNT_W(CNT_W), .RD_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[g]), .abort(abort_v[g]),
      .len(len), .base1_addr(base1), .base2_addr(base2), .init_val(init_val),
      .ram1_addr(a1_v[g]), .ram2_addr(a2_v[g]), .ram_rd_en(rd_v[g]), .sum_0(s0_v[g]),
      .final_sum(fsum), .busy(busy_v[g]), .done(done_v[g]), .result(res_v[g])
    );

    // RAM pipeline; poison value when no read was issued exposes misaligned capture
    always @(posedge clk) begin
      p1[0] <= rd_v[g] ? mem1[g][a1_v[g]] : 32'hBAD0_0001;
      p2[0] <= rd_v[g] ? mem2[g][a2_v[g]] : 32'hBAD0_0002;
      for (int k = 1; k < LAT; k++) begin
        p1[k] <= p1[k-1];
        p2[k] <= p2[k-1];
      end
      fsum <= s0_v[g] + p1[LAT-1] + p2[LAT-1];
    end
  end

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d t=%0t actual=%h expected=%h", name, i, $time, act, exp);
    end
  endtask

  // Job-level model: cycle t after the start edge, period P = RD_LAT+2, done at t = len*P+1
  bit            m_busy[2];
  int            m_t[2];
  int            m_len[2];
  logic [AW-1:0] m_b1[2];
  logic [AW-1:0] m_b2[2];
  logic [AW-1:0] h1[2];
  logic [AW-1:0] h2[2];
  logic [31:0]   h_acc[2];
  logic [31:0]   m_res[2];
  logic [31:0]   psum[2][DEPTH+1];

  always @(posedge clk or negedge rst_n) begin : model
    int d, k, p;
    logic [AW-1:0] ia, ib;
    for (int i = 0; i < 2; i++) begin
      p = lat_of(i) + 2;
      if (!rst_n) begin
        m_busy[i] = 1'b0; m_t[i] = 0; h1[i] = '0; h2[i] = '0; h_acc[i] = '0; m_res[i] = '0;
      end else if (m_busy[i]) begin
        d = m_len[i] * p + 1;
        k = (m_t[i] - 1) / p;
        if (m_t[i] == d) begin
          m_busy[i] = 1'b0;
          m_res[i]  = psum[i][m_len[i]];
          h_acc[i]  = psum[i][m_len[i]];
          h1[i]     = m_b1[i] + AW'(m_len[i]);
          h2[i]     = m_b2[i] + AW'(m_len[i]);
        end else if (abort_v[i]) begin
          m_busy[i] = 1'b0;
          h_acc[i]  = psum[i][k];
          h1[i]     = m_b1[i] + AW'(k);
          h2[i]     = m_b2[i] + AW'(k);
        end else begin
          m_t[i] = m_t[i] + 1;
        end
      end else if (start_v[i] && !abort_v[i]) begin
        m_busy[i] = 1'b1;
        m_t[i]    = 1;
        m_len[i]  = int'(len);
        m_b1[i]   = base1;
        m_b2[i]   = base2;
        psum[i][0] = init_val;
        for (int j = 0; j < m_len[i]; j++) begin
          ia = base1 + AW'(j);
          ib = base2 + AW'(j);
          psum[i][j+1] = psum[i][j] + mem1[i][ia] + mem2[i][ib];
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    int d, k, p;
    logic          e_rd, e_busy, e_done;
    logic [AW-1:0] e_a1, e_a2;
    logic [31:0]   e_acc, e_res;
    for (int i = 0; i < 2; i++) begin
      p = lat_of(i) + 2;
      if (m_busy[i]) begin
        d = m_len[i] * p + 1;
        k = (m_t[i] - 1) / p;
        e_busy = 1'b1;
        e_done = (m_t[i] == d);
        e_rd   = (m_t[i] < d) && ((m_t[i] - 1) % p == 0);
        e_a1   = m_b1[i] + AW'(k);
        e_a2   = m_b2[i] + AW'(k);
        e_acc  = psum[i][k];
        e_res  = e_done ? psum[i][m_len[i]] : m_res[i];
      end else begin
        e_busy = 1'b0; e_done = 1'b0; e_rd = 1'b0;
        e_a1 = h1[i]; e_a2 = h2[i]; e_acc = h_acc[i]; e_res = m_res[i];
      end
      chk("rd_en", i, 32'(rd_v[i]), 32'(e_rd));
      chk("ram1_addr", i, 32'(a1_v[i]), 32'(e_a1));
      chk("ram2_addr", i, 32'(a2_v[i]), 32'(e_a2));
      chk("sum_0", i, s0_v[i], e_acc);
      chk("busy", i, 32'(busy_v[i]), 32'(e_busy));
      chk("done", i, 32'(done_v[i]), 32'(e_done));
      chk("result", i, res_v[i], e_res);
    end
  end

  // Launch one job and watch it; poke raises start again mid-job, abort_at pulses abort
  task automatic run_job(input int i, input int ln, input logic [AW-1:0] b1, input logic [AW-1:0] b2,
                         input logic [31:0] iv, input int poke, input int abort_at,
                         output int dc, output logic [31:0] res, output logic [31:0] mask);
    int c;
    bit fin;
    rda1.delete();
    rda2.delete();
    @(posedge clk); #1;
    len = CNT_W'(ln); base1 = b1; base2 = b2; init_val = iv; start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    dc = 0; mask = '0; c = 0; fin = 1'b0;
    while (!fin) begin
      c++;
      start_v[i] = (c == poke);
      if (c == poke) len = CNT_W'(9);
      abort_v[i] = (c == abort_at);
      @(negedge clk);
      if (rd_v[i]) begin
        if (c < 32) mask[c] = 1'b1;
        rda1.push_back(a1_v[i]);
        rda2.push_back(a2_v[i]);
      end
      if (done_v[i]) begin dc = c; fin = 1'b1; end
      if (abort_at > 0 && c >= abort_at + 3) fin = 1'b1;
      if (c >= 4000) begin
        n_vec++; n_err++;
        $display("FAIL timeout inst%0d no done within %0d cycles", i, c);
        fin = 1'b1;
      end
      @(posedge clk); #1;
    end
    start_v[i] = 1'b0;
    abort_v[i] = 1'b0;
    res = res_v[i];
  endtask

  int          dc;
  logic [31:0] res;
  logic [31:0] mask;
  int          seen_done;

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; abort_v[i] = 1'b0;
      m_busy[i] = 1'b0; m_t[i] = 0; m_len[i] = 0; m_b1[i] = '0; m_b2[i] = '0;
      h1[i] = '0; h2[i] = '0; h_acc[i] = '0; m_res[i] = '0;
      for (int j = 0; j < DEPTH; j++) begin mem1[i][j] = '0; mem2[i][j] = '0; end
    end
    len = '0; base1 = '0; base2 = '0; init_val = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 0, 32'(busy_v[0]), 32'd0);
    chk("reset_result", 1, res_v[1], 32'd0);

    // Basic job: 5 + (1+10) + (2+20) + (3+30) = 71
    mem1[0][0] = 32'd1;  mem1[0][1] = 32'd2;  mem1[0][2] = 32'd3;
    mem2[0][10'h100] = 32'd10; mem2[0][10'h101] = 32'd20; mem2[0][10'h102] = 32'd30;
    run_job(0, 3, 10'h000, 10'h100, 32'd5, 0, 0, dc, res, mask);
    chk("basic_done_cycle", 0, 32'(dc), 32'd10);
    chk("basic_result", 0, res, 32'd71);
    chk("basic_rd_cycles", 0, mask, 32'h0000_0092);
    chk("basic_rd_count", 0, 32'(rda1.size()), 32'd3);
    if (rda1.size() == 3) begin
      chk("basic_addr1_2", 0, 32'(rda1[2]), 32'h002);
      chk("basic_addr2_0", 0, 32'(rda2[0]), 32'h100);
      chk("basic_addr2_2", 0, 32'(rda2[2]), 32'h102);
    end

    run_job(0, 0, 10'h000, 10'h000, 32'h0000_DEAD, 0, 0, dc, res, mask);
    chk("len0_done_cycle", 0, 32'(dc), 32'd1);
    chk("len0_result", 0, res, 32'h0000_DEAD);
    chk("len0_no_rd", 0, mask, 32'd0);

    // Carry out of bit 31 is discarded
    mem1[0][10'h050] = 32'd1;
    run_job(0, 1, 10'h050, 10'h060, 32'hFFFF_FFFF, 0, 0, dc, res, mask);
    chk("wrap_done_cycle", 0, 32'(dc), 32'd4);
    chk("wrap_result", 0, res, 32'd0);

    // Address wrap from 0x3FF to 0: 7+8 + 1+0 = 16
    mem1[0][10'h3FF] = 32'd7; mem2[0][10'h3FF] = 32'd8;
    run_job(0, 2, 10'h3FF, 10'h3FF, 32'd0, 0, 0, dc, res, mask);
    chk("awrap_result", 0, res, 32'd16);
    chk("awrap_rd_count", 0, 32'(rda1.size()), 32'd2);
    if (rda1.size() == 2) begin
      chk("awrap_addr1", 0, 32'(rda1[1]), 32'd0);
      chk("awrap_addr2", 0, 32'(rda2[1]), 32'd0);
    end

    // Abort during the WAIT of the second pair: no done, result keeps 16
    run_job(0, 4, 10'h000, 10'h100, 32'd1, 0, 5, dc, res, mask);
    chk("abort_no_done", 0, 32'(dc), 32'd0);
    chk("abort_result", 0, res, 32'd16);
    run_job(0, 3, 10'h000, 10'h100, 32'd5, 0, 0, dc, res, mask);
    chk("restart_done_cycle", 0, 32'(dc), 32'd10);
    chk("restart_result", 0, res, 32'd71);

    // start and abort together in IDLE: stays idle
    @(posedge clk); #1;
    len = CNT_W'(2); start_v[0] = 1'b1; abort_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0; abort_v[0] = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", 0, 32'(busy_v[0]), 32'd0);

    // RD_LAT=3, start poked while busy: 100 + (4+6) + (5+7) = 122, done at 2*5+1
    mem1[1][0] = 32'd4; mem1[1][1] = 32'd5;
    mem2[1][10'h200] = 32'd6; mem2[1][10'h201] = 32'd7;
    run_job(1, 2, 10'h000, 10'h200, 32'd100, 3, 0, dc, res, mask);
    chk("lat3_done_cycle", 1, 32'(dc), 32'd11);
    chk("lat3_result", 1, res, 32'd122);
    chk("lat3_rd_cycles", 1, mask, 32'h0000_0042);
    repeat (3) @(negedge clk);
    chk("lat3_poke_ignored", 1, 32'(busy_v[1]), 32'd0);

    // Maximum length: 1023 pairs of (1+2), done at 1023*3+1
    for (int j = 0; j < DEPTH; j++) begin mem1[0][j] = 32'd1; mem2[0][j] = 32'd2; end
    run_job(0, 1023, 10'h000, 10'h000, 32'd0, 0, 0, dc, res, mask);
    chk("maxlen_done_cycle", 0, 32'(dc), 32'd3070);
    chk("maxlen_result", 0, res, 32'd3069);

    // Asynchronous reset in the middle of WAIT
    @(posedge clk); #1;
    len = CNT_W'(3); base1 = 10'h010; base2 = 10'h020; init_val = 32'd9; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_busy", 0, 32'(busy_v[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_en", 0, 32'(rd_v[0]), 32'd0);
    chk("rst_addr1", 0, 32'(a1_v[0]), 32'd0);
    chk("rst_addr2", 0, 32'(a2_v[0]), 32'd0);
    chk("rst_sum_0", 0, s0_v[0], 32'd0);
    chk("rst_busy", 0, 32'(busy_v[0]), 32'd0);
    chk("rst_done", 0, 32'(done_v[0]), 32'd0);
    chk("rst_result", 0, res_v[0], 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0]) seen_done++;
    end
    chk("rst_no_done", 0, 32'(seen_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
